// File: rtl/loop_nest_pkg.sv
// Shared types and helpers for the nested-loop sequencer.
// Level i of a packed bound/count vector lives at bits [i*CNT_W +: CNT_W].
package loop_nest_pkg;

  localparam int unsigned DefLevels = 3;
  localparam int unsigned DefCntW   = 10;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic int unsigned field_lsb(int unsigned lvl, int unsigned cnt_w);
    return lvl * cnt_w;
  endfunction

endpackage

// File: rtl/loop_nest_seq_if.sv
// Config, step and strobe bundle between the sequencer and its controller.
interface loop_nest_seq_if
  import loop_nest_pkg::*;
#(
  parameter int unsigned LEVELS = DefLevels,
  parameter int unsigned CNT_W  = DefCntW
);

  logic                    cfg_vld;
  logic                    cfg_rdy;
  logic [LEVELS*CNT_W-1:0] cfg_bound;
  logic                    abort;
  logic                    step_vld;
  logic                    step_rdy;
  logic [LEVELS*CNT_W-1:0] cnt;
  logic [LEVELS-1:0]       lvl_start;
  logic [LEVELS-1:0]       lvl_max;
  logic [LEVELS-1:0]       lvl_wrap;
  logic                    done;
  logic                    busy;

  modport master (
    output cfg_vld, cfg_bound, abort, step_vld,
    input  cfg_rdy, step_rdy, cnt, lvl_start, lvl_max, lvl_wrap, done, busy
  );

  modport slave (
    input  cfg_vld, cfg_bound, abort, step_vld,
    output cfg_rdy, step_rdy, cnt, lvl_start, lvl_max, lvl_wrap, done, busy
  );

endinterface

// File: rtl/loop_level_cnt.sv
// One loop level: counts 0..bound-1 on en, wrapping to 0 after the max index.
module loop_level_cnt
  import loop_nest_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] bound,
  output logic [CNT_W-1:0] cnt,
  output logic             is_max,
  output logic             wraps
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt    = cnt_q;
  assign is_max = (cnt_q == bound - CNT_W'(1));
  assign wraps  = is_max & en;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= is_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/loop_nest_seq.sv
// Parametrised nested-loop sequencer: captures per-level bounds, then walks the nest one
// beat per step handshake, emitting per-level start/max/wrap strobes and a done pulse.
module loop_nest_seq
  import loop_nest_pkg::*;
#(
  parameter int unsigned LEVELS = DefLevels,
  parameter int unsigned CNT_W  = DefCntW
) (
  input logic            clk,
  input logic            rst,
  loop_nest_seq_if.slave bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  state_e              state_q;
  logic                cfg_rdy_q;
  logic                step_rdy_q;
  logic                busy_q;
  cnt_t [LEVELS-1:0]   bounds_q;
  cnt_t [LEVELS-1:0]   bounds_cap;
  cnt_t [LEVELS-1:0]   cnt_arr;
  logic [LEVELS-1:0]   is_max;
  logic [LEVELS-1:0]   wraps;
  logic [LEVELS-1:0]   chain;
  logic [LEVELS-1:0]   en;
  logic [LEVELS-1:0]   start_vec;
  logic                fire;
  logic                clr;
  logic                done;

  assign fire = bus.step_vld & step_rdy_q;
  // Abort still lets this cycle's strobes out, but the clear beats the count update.
  assign clr  = (state_q == StRun) & bus.abort;
  assign done = wraps[LEVELS-1];

  always_comb begin
    bounds_cap = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      bounds_cap[i] = bus.cfg_bound[field_lsb(i, CNT_W) +: CNT_W];
      if (bounds_cap[i] == '0) begin
        bounds_cap[i] = CNT_W'(1);
      end
    end
  end

  // Enable chain built from is_max alone so no level feeds back into its own enable.
  always_comb begin
    chain    = '0;
    en       = '0;
    chain[0] = is_max[0] & fire;
    en[0]    = fire;
    for (int unsigned i = 1; i < LEVELS; i++) begin
      chain[i] = is_max[i] & chain[i-1];
      en[i]    = chain[i-1];
    end
  end

  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    loop_level_cnt #(
      .CNT_W (CNT_W)
    ) u_lvl (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en[g]),
      .bound  (bounds_q[g]),
      .cnt    (cnt_arr[g]),
      .is_max (is_max[g]),
      .wraps  (wraps[g])
    );
    assign start_vec[g] = fire & (cnt_arr[g] == '0);
  end

  assign bus.cnt       = cnt_arr;
  assign bus.lvl_start = start_vec;
  assign bus.lvl_max   = is_max & {LEVELS{fire}};
  assign bus.lvl_wrap  = wraps;
  assign bus.done      = done;
  assign bus.cfg_rdy   = cfg_rdy_q;
  assign bus.step_rdy  = step_rdy_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cfg_rdy_q  <= 1'b1;
      step_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      bounds_q   <= {LEVELS{CNT_W'(1)}};
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cfg_vld && !bus.abort) begin
            state_q    <= StRun;
            cfg_rdy_q  <= 1'b0;
            step_rdy_q <= 1'b1;
            busy_q     <= 1'b1;
            bounds_q   <= bounds_cap;
          end
        end
        StRun: begin
          if (bus.abort || done) begin
            state_q    <= StIdle;
            cfg_rdy_q  <= 1'b1;
            step_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          cfg_rdy_q  <= 1'b1;
          step_rdy_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_seq.sv
// Scoreboard bench for loop_nest_seq: the driver queues the expected strobes of every beat,
// a negedge monitor pops and compares them whenever a beat fires.
module tb_loop_nest_seq;

  localparam int unsigned LEVELS = 3;
  localparam int unsigned CNT_W  = 10;

  typedef struct packed {
    logic [29:0] cnt;
    logic [2:0]  st;
    logic [2:0]  mx;
    logic [2:0]  wr;
    logic        dn;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n_done;
  int   exp_done;
  bit   started;
  exp_t sb[$];

  loop_nest_seq_if #(.LEVELS(LEVELS), .CNT_W(CNT_W)) bus ();

  loop_nest_seq #(
    .LEVELS (LEVELS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Independent nest model: beat k decomposed as mixed-radix digits of the clamped bounds.
  function automatic exp_t exp_for(int b2, int b1, int b0, int k);
    exp_t e;
    int   i0, i1, i2;
    i0   = k % b0;
    i1   = (k / b0) % b1;
    i2   = k / (b0 * b1);
    e.cnt = {10'(i2), 10'(i1), 10'(i0)};
    e.st  = {i2 == 0, i1 == 0, i0 == 0};
    e.mx  = {i2 == b2 - 1, i1 == b1 - 1, i0 == b0 - 1};
    e.wr[0] = e.mx[0];
    e.wr[1] = e.mx[1] & e.wr[0];
    e.wr[2] = e.mx[2] & e.wr[1];
    e.dn    = e.wr[2];
    return e;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      if (bus.step_vld && bus.step_rdy) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_fire: got a beat, expected none queued");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cnt", 32'(bus.cnt), 32'(e.cnt));
          check("lvl_start", 32'(bus.lvl_start), 32'(e.st));
          check("lvl_max", 32'(bus.lvl_max), 32'(e.mx));
          check("lvl_wrap", 32'(bus.lvl_wrap), 32'(e.wr));
          check("done", 32'(bus.done), 32'(e.dn));
          if (bus.done) n_done++;
        end
      end else begin
        check("idle_strobes", 32'({bus.lvl_start, bus.lvl_max, bus.lvl_wrap, bus.done}), 32'd0);
      end
    end
  end

  task automatic run_nest(input int r2, input int r1, input int r0, input bit toggle,
                          input bit poke, input int abort_at, input int stop_at);
    int   b2, b1, b0, n;
    exp_t e;
    b2 = (r2 == 0) ? 1 : r2;
    b1 = (r1 == 0) ? 1 : r1;
    b0 = (r0 == 0) ? 1 : r0;
    n  = (stop_at >= 0) ? stop_at : b2 * b1 * b0;
    check("cfg_rdy_pre", 32'(bus.cfg_rdy), 32'd1);
    bus.cfg_bound = {10'(r2), 10'(r1), 10'(r0)};
    bus.cfg_vld   = 1'b1;
    @(posedge clk); #1;
    bus.cfg_vld = 1'b0;
    check("busy_run", 32'(bus.busy), 32'd1);
    check("step_rdy_run", 32'(bus.step_rdy), 32'd1);
    for (int k = 0; k < n; k++) begin
      e = exp_for(b2, b1, b0, k);
      if (toggle) begin
        bus.step_vld = 1'b0;
        check("cnt_hold", 32'(bus.cnt), 32'(e.cnt));
        @(posedge clk); #1;
      end
      sb.push_back(e);
      bus.step_vld = 1'b1;
      if (poke && k == 3) begin
        check("cfg_rdy_run", 32'(bus.cfg_rdy), 32'd0);
        bus.cfg_vld   = 1'b1;
        bus.cfg_bound = {10'd1, 10'd1, 10'd2};
      end
      if (k == abort_at) bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.cfg_vld = 1'b0;
      bus.abort   = 1'b0;
      if (k == abort_at) begin
        bus.step_vld = 1'b0;
        check("abort_cnt", 32'(bus.cnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
        check("abort_step_rdy", 32'(bus.step_rdy), 32'd0);
        return;
      end
    end
    bus.step_vld = 1'b0;
    if (stop_at < 0) begin
      exp_done++;
      check("end_busy", 32'(bus.busy), 32'd0);
      check("end_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
      check("end_step_rdy", 32'(bus.step_rdy), 32'd0);
      check("end_cnt", 32'(bus.cnt), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; n_done = 0; exp_done = 0; started = 1'b0;
    rst = 1'b1;
    bus.cfg_vld = 1'b0; bus.cfg_bound = '0; bus.abort = 1'b0; bus.step_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    check("rst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    check("rst_step_rdy", 32'(bus.step_rdy), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.cnt), 32'd0);
    check("rst_bounds", 32'(dut.bounds_q), 32'({10'd1, 10'd1, 10'd1}));

    run_nest(2, 3, 4, 1'b0, 1'b0, -1, -1);
    run_nest(2, 3, 4, 1'b1, 1'b0, -1, -1);
    run_nest(0, 1, 5, 1'b0, 1'b0, -1, -1);
    run_nest(2, 3, 4, 1'b0, 1'b1, -1, -1);
    run_nest(2, 3, 4, 1'b0, 1'b0, 6, -1);
    run_nest(1, 2, 3, 1'b0, 1'b0, -1, -1);

    // Park the nest at cnt={1,2,3} (beat 23 of 24), then reset mid-RUN.
    run_nest(2, 3, 4, 1'b0, 1'b0, -1, 23);
    check("park_cnt", 32'(bus.cnt), 32'({10'd1, 10'd2, 10'd3}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    check("mid_rst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    check("mid_rst_step_rdy", 32'(bus.step_rdy), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_bounds", 32'(dut.bounds_q), 32'({10'd1, 10'd1, 10'd1}));
    repeat (2) @(posedge clk);
    #1;

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
